serial_adder: RTL and testbench

Bit-serial, parametrised adder/subtractor built around a single full-adder cell. It is the sequential successor to the team's combinational half adder. Operands of WIDTH bits are latched on a start request and processed one bit per clock, LSB first. The result and carry are published together with a one-cycle done pulse. It serves datapaths where area matters more than latency, and is the template for the team's later multi-cycle arithmetic blocks.

---
 rtl/serial_adder_if.sv | 30 +++
 rtl/serial_adder.sv | 141 ++++++++++++++
 tb/tb_serial_adder.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// ---------------------------------------------------------------------------
// serial_adder_if
// Request/response bundle for the bit-serial adder/subtractor.
//   master : drives start/sub/a/b/cin, observes busy/done/sum/carry
//   slave  : the adder itself
// Parameter WIDTH must match the attached serial_adder instance.
// ---------------------------------------------------------------------------
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry;

   modport master (
      output start, sub, a, b, cin,
      input  busy, done, sum, carry
   );

   modport slave (
      input  start, sub, a, b, cin,
      output busy, done, sum, carry
   );
endinterface

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
// Bit-serial adder/subtractor built around one full-adder cell. Operands are
// latched when a start request is accepted (busy=0) and consumed LSB first,
// one bit per clock. sum/carry are published together with a one-cycle done
// pulse and held until the next completion.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : serial_adder_if.slave
//              start  request, accepted only while busy=0
//              sub    0: a+b+cin   1: a-b as a+~b+1 (cin ignored)
//              a, b   operands, sampled on the accepting edge only
//              cin    carry in, sampled on the accepting edge only
//              busy   computation in progress
//              done   one-cycle pulse, sum/carry valid from this cycle
//              sum    result, held until the next completion
//              carry  carry out; for sub=1 the no-borrow flag (a>=b)
// Latency: start accepted at edge k -> done after edge k+WIDTH.
// ---------------------------------------------------------------------------
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   serial_adder_if.slave  bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic             accept;
   logic             last;

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh;     // bit 0 is always the bit being processed
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;   // partial result, filled from the MSB side
   logic [WIDTH-1:0] res_nx;
   logic             c;        // running carry between bit slices
   logic             s_bit;
   logic             c_nx;

   logic [WIDTH-1:0] sum_q;
   logic             carry_q;

   // ---- full-adder cell ---------------------------------------------------
   assign s_bit = a_sh[0] ^ b_sh[0] ^ c;
   assign c_nx  = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
   assign last  = (cnt == CW'(WIDTH - 1));

   // After WIDTH shifts the first bit in has travelled down to bit 0, so the
   // register holds the result in natural order without any reversal.
   generate
      if (WIDTH == 1) begin : g_res_w1
         assign res_nx = s_bit;
      end else begin : g_res_wn
         assign res_nx = {s_bit, res_sh[WIDTH-1:1]};
      end
   endgenerate

   // ---- control FSM -------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // DONE accepts a new request just like IDLE so start held high gives
   // one result every WIDTH+1 cycles.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            if (last) state_nx = DONE;
         end
         DONE: begin
            if (bus.start) begin
               accept   = 1'b1;
               state_nx = RUN;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // ---- datapath ----------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         res_sh  <= '0;
         c       <= 1'b0;
         cnt     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else if (accept) begin
         // Subtract folds into the add path: a + ~b + 1.
         a_sh   <= bus.a;
         b_sh   <= bus.sub ? ~bus.b : bus.b;
         c      <= bus.sub ? 1'b1 : bus.cin;
         res_sh <= '0;
         cnt    <= '0;
      end else if (state == RUN) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         c      <= c_nx;
         res_sh <= res_nx;
         cnt    <= cnt + CW'(1);
         // Only the completion edge touches the visible result, so partial
         // bits never appear on sum.
         if (last) begin
            sum_q   <= res_nx;
            carry_q <= c_nx;
         end
      end
   end

   // Outputs are decodes of registered state or registers: no input-to-output
   // combinational path.
   assign bus.busy  = (state == RUN);
   assign bus.done  = (state == DONE);
   assign bus.sum   = sum_q;
   assign bus.carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
// Drives three serial_adder instances (WIDTH 8, 1, 16) and compares their
// results and timing against a plain-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_adder_if #(.WIDTH(8))  if8  ();
   serial_adder_if #(.WIDTH(1))  if1  ();
   serial_adder_if #(.WIDTH(16)) if16 ();

   serial_adder #(.WIDTH(8))  u_w8  (.clk(clk), .rst_n(rst_n), .bus(if8));
   serial_adder #(.WIDTH(1))  u_w1  (.clk(clk), .rst_n(rst_n), .bus(if1));
   serial_adder #(.WIDTH(16)) u_w16 (.clk(clk), .rst_n(rst_n), .bus(if16));

   int          total = 0;
   int          bad   = 0;
   logic [63:0] prev_s [3];
   logic        prev_c [3];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int wid(input int sel);
      case (sel)
         0:       return 8;
         1:       return 1;
         default: return 16;
      endcase
   endfunction

   // Reference: unsigned arithmetic on masked operands.
   function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub,
                                 output logic [63:0] s, output logic c);
      logic [64:0] t;
      logic [63:0] m, am, bm;
      m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      am = a & m;
      bm = b & m;
      if (sub) begin
         s = (am - bm) & m;
         c = (am >= bm);
      end else begin
         t = {1'b0, am} + {1'b0, bm} + 65'(cin);
         s = t[63:0] & m;
         c = t[w];
      end
   endfunction

   task automatic drive(input int sel, input logic st, input logic [63:0] a,
                        input logic [63:0] b, input logic cin, input logic sub);
      case (sel)
         0: begin if8.start = st;  if8.a = a[7:0];   if8.b = b[7:0];   if8.cin = cin;  if8.sub = sub;  end
         1: begin if1.start = st;  if1.a = a[0:0];   if1.b = b[0:0];   if1.cin = cin;  if1.sub = sub;  end
         default: begin if16.start = st; if16.a = a[15:0]; if16.b = b[15:0]; if16.cin = cin; if16.sub = sub; end
      endcase
   endtask

   task automatic set_start(input int sel, input logic st);
      case (sel)
         0:       if8.start  = st;
         1:       if1.start  = st;
         default: if16.start = st;
      endcase
   endtask

   task automatic peek(input int sel, output logic bsy, output logic dn,
                       output logic [63:0] s, output logic c);
      case (sel)
         0:       begin bsy = if8.busy;  dn = if8.done;  s = 64'(if8.sum);  c = if8.carry;  end
         1:       begin bsy = if1.busy;  dn = if1.done;  s = 64'(if1.sum);  c = if1.carry;  end
         default: begin bsy = if16.busy; dn = if16.done; s = 64'(if16.sum); c = if16.carry; end
      endcase
   endtask

   // One operation: request, optional input churn while busy, completion and
   // latency check, then confirm done drops and the result is held.
   task automatic run_op(input int sel, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sub, input bit disturb);
      logic [63:0] es, s;
      logic        ec, c, bsy, dn;
      int          w, lat;
      bit          got;
      w   = wid(sel);
      got = 0;
      lat = 0;
      model(w, a, b, cin, sub, es, ec);
      @(negedge clk);
      drive(sel, 1'b1, a, b, cin, sub);
      @(posedge clk);
      for (int i = 0; i <= w + 8; i++) begin
         @(negedge clk);
         peek(sel, bsy, dn, s, c);
         if (dn) begin
            set_start(sel, 1'b0);
            lat = i;
            got = 1;
            break;
         end
         chk("busy_run", 64'(bsy), 64'd1);
         chk("sum_hold", s, prev_s[sel]);
         chk("carry_hold", 64'(c), 64'(prev_c[sel]));
         if (disturb)
            drive(sel, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom), 1'($urandom));
         else
            set_start(sel, 1'b0);
      end
      if (!got) begin
         chk("done_timeout", 64'd0, 64'd1);
         set_start(sel, 1'b0);
      end else begin
         chk("latency", 64'(lat), 64'(w));
         chk("sum", s, es);
         chk("carry", 64'(c), 64'(ec));
         chk("busy_at_done", 64'(bsy), 64'd0);
         @(negedge clk);
         peek(sel, bsy, dn, s, c);
         chk("done_pulse", 64'(dn), 64'd0);
         chk("sum_after", s, es);
         chk("carry_after", 64'(c), 64'(ec));
      end
      prev_s[sel] = es;
      prev_c[sel] = ec;
   endtask

   initial begin
      logic [63:0] s, e1s, e2s;
      logic        c, bsy, dn, e1c, e2c;
      int          t1, t2, ndone;
      bit          seen;

      for (int k = 0; k < 3; k++) begin
         drive(k, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
         prev_s[k] = '0;
         prev_c[k] = 1'b0;
      end

      // ---- reset state ----
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         peek(k, bsy, dn, s, c);
         chk("rst_busy", 64'(bsy), 64'd0);
         chk("rst_done", 64'(dn), 64'd0);
         chk("rst_sum", s, 64'd0);
         chk("rst_carry", 64'(c), 64'd0);
      end
      rst_n = 1'b1;

      // ---- directed WIDTH=8 ----
      run_op(0, 64'h00, 64'h00, 1'b0, 1'b0, 0);
      run_op(0, 64'hFF, 64'h01, 1'b0, 1'b0, 0);
      run_op(0, 64'hA5, 64'h5A, 1'b1, 1'b0, 0);
      run_op(0, 64'h3C, 64'h0F, 1'b0, 1'b0, 0);
      chk("dir_3c0f", prev_s[0], 64'h4B);
      run_op(0, 64'h10, 64'h01, 1'b0, 1'b1, 0);
      chk("dir_sub1", prev_s[0], 64'h0F);
      run_op(0, 64'h01, 64'h02, 1'b0, 1'b1, 0);
      chk("dir_sub2", prev_s[0], 64'hFF);
      run_op(0, 64'h55, 64'h55, 1'b1, 1'b1, 0);
      chk("dir_sub3c", 64'(prev_c[0]), 64'd1);

      // ---- inputs ignored while busy, exactly one done ----
      run_op(0, 64'h01, 64'h01, 1'b0, 1'b0, 1);
      chk("ign_sum", prev_s[0], 64'h02);
      ndone = 0;
      repeat (6) begin
         @(negedge clk);
         peek(0, bsy, dn, s, c);
         if (dn) ndone++;
      end
      chk("ign_one_done", 64'(ndone), 64'd0);

      // ---- back-to-back with start held high ----
      model(8, 64'h12, 64'h34, 1'b1, 1'b0, e1s, e1c);
      model(8, 64'h80, 64'h90, 1'b0, 1'b1, e2s, e2c);
      @(negedge clk);
      drive(0, 1'b1, 64'h12, 64'h34, 1'b1, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b1, 64'h80, 64'h90, 1'b0, 1'b1);
      t1 = -1;
      t2 = -1;
      for (int i = 0; i < 30; i++) begin
         peek(0, bsy, dn, s, c);
         if (dn) begin
            t1 = cyc;
            chk("b2b_sum1", s, e1s);
            chk("b2b_carry1", 64'(c), 64'(e1c));
            break;
         end
         @(negedge clk);
      end
      if (t1 < 0) chk("b2b_timeout1", 64'd0, 64'd1);
      @(negedge clk);
      peek(0, bsy, dn, s, c);
      chk("b2b_reaccept", 64'(bsy), 64'd1);
      for (int i = 0; i < 30; i++) begin
         peek(0, bsy, dn, s, c);
         if (dn) begin
            t2 = cyc;
            set_start(0, 1'b0);
            chk("b2b_sum2", s, e2s);
            chk("b2b_carry2", 64'(c), 64'(e2c));
            break;
         end
         @(negedge clk);
      end
      set_start(0, 1'b0);
      if (t2 < 0) chk("b2b_timeout2", 64'd0, 64'd1);
      else        chk("b2b_spacing", 64'(t2 - t1), 64'd9);
      prev_s[0] = e2s;
      prev_c[0] = e2c;

      // ---- reset in the middle of RUN ----
      @(negedge clk);
      drive(0, 1'b1, 64'hFF, 64'h01, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      set_start(0, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      peek(0, bsy, dn, s, c);
      chk("mid_rst_busy", 64'(bsy), 64'd0);
      chk("mid_rst_done", 64'(dn), 64'd0);
      chk("mid_rst_sum", s, 64'd0);
      chk("mid_rst_carry", 64'(c), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         peek(0, bsy, dn, s, c);
         if (dn || bsy) seen = 1;
      end
      chk("mid_rst_quiet", 64'(seen), 64'd0);
      for (int k = 0; k < 3; k++) begin
         prev_s[k] = '0;
         prev_c[k] = 1'b0;
      end
      run_op(0, 64'h7E, 64'h81, 1'b1, 1'b0, 0);

      // ---- WIDTH=1 exhaustive ----
      for (int v = 0; v < 16; v++)
         run_op(1, 64'(v & 1), 64'((v >> 1) & 1), 1'((v >> 2) & 1), 1'((v >> 3) & 1), 0);

      // ---- random WIDTH=8 and WIDTH=16 with input churn while busy ----
      for (int n = 0; n < 200; n++)
         run_op(0, 64'($urandom), 64'($urandom), 1'($urandom), 1'($urandom), 1);
      for (int n = 0; n < 1000; n++)
         run_op(2, 64'($urandom), 64'($urandom), 1'($urandom), 1'($urandom), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
